pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the generic successor to the fixed single-lane stage registers (DT→DC, DC→MEM, …). Carries LANES parallel issue slots per cycle with per-lane valid bits, applies the core-wide stall vector, flush and same-cycle lane kills, and optionally packs surviving lanes toward lane 0. Every pipeline boundary of the dual-issue core instantiates one copy. Optional performance counters record advance, hold, bubble and flush events.

---
 rtl/pipe_stage_reg_pkg.sv | 16 +
 rtl/pipe_stage_perf_cnt.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-control definitions: stall encoding, stall bus width and per-cycle stage actions.
package pipe_stage_reg_pkg;

  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;
  localparam int   STALL_BUS_W = 8;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADV,
    ACT_HOLD
  } stage_act_e;

endpackage

// File: rtl/pipe_stage_perf_cnt.sv
// Saturating advance/hold/bubble/flush event counters; counts land one cycle after the event.
module pipe_stage_perf_cnt
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  stage_act_e       act,
  output logic [CNT_W-1:0] cnt_adv,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_flush
);

  logic [3:0]            inc;
  logic [CNT_W-1:0]      cnt_d [4];
  logic [CNT_W-1:0]      cnt_q [4];

  assign inc = {act == ACT_FLUSH, act == ACT_BUBBLE, act == ACT_HOLD, act == ACT_ADV};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rst) begin
        cnt_d[i] = '0;
      end else if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_adv    = cnt_q[0];
  assign cnt_hold   = cnt_q[1];
  assign cnt_bubble = cnt_q[2];
  assign cnt_flush  = cnt_q[3];

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane inter-stage register with stall/flush/kill and optional lane compaction; 1-cycle latency.
// Event counters exist only when PIPE_STAGE_PERF_EN is defined, otherwise the counter ports read 0.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LANES   = 2,
  parameter int STALL_W = STALL_BUS_W,
  parameter int STAGE   = 6,
  parameter int COMPACT = 1,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [STALL_W-1:0]     stall,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       kill_mask,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       cnt_adv,
  output logic [CNT_W-1:0]       cnt_hold,
  output logic [CNT_W-1:0]       cnt_bubble,
  output logic [CNT_W-1:0]       cnt_flush
);

  logic                   s, n;
  logic                   unused_stall;
  stage_act_e             act;
  logic [LANES-1:0]       v, pack_v, cap_v;
  logic [LANES*WIDTH-1:0] masked_dat, pack_dat, cap_dat;
  logic [LANES-1:0]       valid_d, valid_q;
  logic [LANES*WIDTH-1:0] data_d, data_q;

  assign s            = stall[STAGE];
  assign n            = stall[STAGE+1];
  assign unused_stall = ^stall;
  assign v            = in_valid & ~kill_mask;

  // Killed and invalid lanes are zeroed before packing so no stale payload survives.
  always_comb begin
    int unsigned k;
    masked_dat = '0;
    pack_dat   = '0;
    pack_v     = '0;
    k          = 0;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) begin
        masked_dat[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
        pack_dat[k*WIDTH +: WIDTH]   = in_data[i*WIDTH +: WIDTH];
        pack_v[k]                    = 1'b1;
        k                            = k + 1;
      end
    end
  end

  assign cap_v   = (COMPACT != 0) ? pack_v   : v;
  assign cap_dat = (COMPACT != 0) ? pack_dat : masked_dat;

  always_comb begin
    if (rst)                              act = ACT_RESET;
    else if (flush)                       act = ACT_FLUSH;
    else if (s == STOP && n == NO_STOP)   act = ACT_BUBBLE;
    else if (s == NO_STOP)                act = ACT_ADV;
    else                                  act = ACT_HOLD;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (act)
      ACT_ADV: begin
        valid_d = cap_v;
        data_d  = cap_dat;
      end
      ACT_HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      default: begin
        valid_d = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .rst        (rst),
    .act        (act),
    .cnt_adv    (cnt_adv),
    .cnt_hold   (cnt_hold),
    .cnt_bubble (cnt_bubble),
    .cnt_flush  (cnt_flush)
  );
`else
  assign cnt_adv    = '0;
  assign cnt_hold   = '0;
  assign cnt_bubble = '0;
  assign cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Vector table plus scoreboard bench for pipe_stage_reg (2 lanes, compaction on, 4-bit counters).
module tb_pipe_stage_reg;

  localparam int W  = 64;
  localparam int L  = 2;
  localparam int SW = 8;
  localparam int CW = 4;

  localparam int A_NONE = 0, A_ADV = 1, A_HOLD = 2, A_BUB = 3, A_FL = 4;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [SW-1:0]     stall;
  logic [L-1:0]      in_valid, kill_mask, out_valid;
  logic [L*W-1:0]    in_data, out_data;
  logic [CW-1:0]     cnt_adv, cnt_hold, cnt_bubble, cnt_flush;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(W), .LANES(L), .STALL_W(SW), .STAGE(6), .COMPACT(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .kill_mask(kill_mask),
    .out_valid(out_valid), .out_data(out_data),
    .cnt_adv(cnt_adv), .cnt_hold(cnt_hold), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
  );

  typedef struct {
    string        name;
    logic         r, f;
    logic [SW-1:0] st;
    logic [L-1:0] vin, kill;
    logic [W-1:0] d0, d1;
    logic [L-1:0] ev;
    logic [W-1:0] e0, e1;
    int           act;
  } vec_t;

  typedef struct {
    string          name;
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    logic [4*CW-1:0] c;
  } exp_t;

  vec_t          tbl [20];
  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_adv = '0, m_hold = '0, m_bub = '0, m_fl = '0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == {CW{1'b1}}) ? x : x + 1'b1;
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic f, input logic [SW-1:0] st,
                              input logic [L-1:0] vin, input logic [L-1:0] kill,
                              input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [L-1:0] ev, input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input int act);
    vec_t t;
    t.name = nm; t.r = r; t.f = f; t.st = st; t.vin = vin; t.kill = kill;
    t.d0 = d0; t.d1 = d1; t.ev = ev; t.e0 = e0; t.e1 = e1; t.act = act;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [L*W-1:0] got, input logic [L*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Drive one vector and push what the register and counters must show after the next edge.
  task automatic drive_push(input vec_t t);
    exp_t e;
    rst = t.r; flush = t.f; stall = t.st; in_valid = t.vin; kill_mask = t.kill;
    in_data = {t.d1, t.d0};
    if (t.r) begin
      m_adv = '0; m_hold = '0; m_bub = '0; m_fl = '0;
    end else begin
      case (t.act)
        A_ADV:   m_adv  = sat_inc(m_adv);
        A_HOLD:  m_hold = sat_inc(m_hold);
        A_BUB:   m_bub  = sat_inc(m_bub);
        A_FL:    m_fl   = sat_inc(m_fl);
        default: ;
      endcase
    end
    e.name = t.name;
    e.v    = t.ev;
    e.d    = {t.e1, t.e0};
`ifdef PIPE_STAGE_PERF_EN
    e.c    = {m_adv, m_hold, m_bub, m_fl};
`else
    e.c    = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic clock_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_valid"}, {{(L*W-L){1'b0}}, out_valid}, {{(L*W-L){1'b0}}, e.v});
      chk({e.name, "_data"}, out_data, e.d);
      chk({e.name, "_cnt"}, {{(L*W-4*CW){1'b0}}, cnt_adv, cnt_hold, cnt_bubble, cnt_flush},
          {{(L*W-4*CW){1'b0}}, e.c});
    end
  endtask

  initial begin
    vec_t t;
    rst = 1'b1; flush = 1'b0; stall = '0; in_valid = '0; kill_mask = '0; in_data = '0;

    //             name            r  f  stall   vin    kill   d0            d1           ev     e0           e1     act
    tbl[0]  = mk("rst0",         1, 0, 8'h00, 2'b11, 2'b00, 64'h99,       64'h98,      2'b00, 64'h0,       64'h0, A_NONE);
    tbl[1]  = mk("rst1",         1, 0, 8'h00, 2'b00, 2'b00, 64'h0,        64'h0,       2'b00, 64'h0,       64'h0, A_NONE);
    tbl[2]  = mk("adv_ab",       0, 0, 8'h00, 2'b11, 2'b00, 64'hA,        64'hB,       2'b11, 64'hA,       64'hB, A_ADV);
    tbl[3]  = mk("hold_ign",     0, 0, 8'hC0, 2'b00, 2'b11, 64'h1234,     64'h5678,    2'b11, 64'hA,       64'hB, A_HOLD);
    tbl[4]  = mk("bubble",       0, 0, 8'h40, 2'b11, 2'b00, 64'h1,        64'h2,       2'b00, 64'h0,       64'h0, A_BUB);
    tbl[5]  = mk("kill_pack",    0, 0, 8'h00, 2'b11, 2'b01, 64'h33,       64'h55,      2'b01, 64'h55,      64'h0, A_ADV);
    tbl[6]  = mk("pack_hi",      0, 0, 8'h80, 2'b10, 2'b00, 64'h77,       64'h99,      2'b01, 64'h99,      64'h0, A_ADV);
    tbl[7]  = mk("lane0_only",   0, 0, 8'h00, 2'b01, 2'b00, 64'h12,       64'h34,      2'b01, 64'h12,      64'h0, A_ADV);
    tbl[8]  = mk("kill_hi",      0, 0, 8'h00, 2'b11, 2'b10, 64'h1111,     64'h2222,    2'b01, 64'h1111,    64'h0, A_ADV);
    tbl[9]  = mk("adv_wide",     0, 0, 8'h3F, 2'b11, 2'b00, 64'hDEADBEEF_0BADF00D, 64'hFFFF_FFFF_FFFF_FFFF,
                                                                                       2'b11, 64'hDEADBEEF_0BADF00D, 64'hFFFF_FFFF_FFFF_FFFF, A_ADV);
    tbl[10] = mk("hold_kill",    0, 0, 8'hC0, 2'b11, 2'b11, 64'h0,        64'h0,       2'b11, 64'hDEADBEEF_0BADF00D, 64'hFFFF_FFFF_FFFF_FFFF, A_HOLD);
    tbl[11] = mk("flush_hold",   0, 1, 8'hC0, 2'b11, 2'b00, 64'h7,        64'h8,       2'b00, 64'h0,       64'h0, A_FL);
    tbl[12] = mk("adv_empty",    0, 0, 8'h00, 2'b00, 2'b00, 64'hAAAA,     64'hBBBB,    2'b00, 64'h0,       64'h0, A_ADV);
    tbl[13] = mk("flush_adv",    0, 1, 8'h00, 2'b11, 2'b00, 64'h3,        64'h4,       2'b00, 64'h0,       64'h0, A_FL);
    tbl[14] = mk("adv_12",       0, 0, 8'h00, 2'b11, 2'b00, 64'h1,        64'h2,       2'b11, 64'h1,       64'h2, A_ADV);
    tbl[15] = mk("hold_ff",      0, 0, 8'hFF, 2'b11, 2'b11, 64'h0,        64'h0,       2'b11, 64'h1,       64'h2, A_HOLD);
    tbl[16] = mk("kill_nosticky",0, 0, 8'h00, 2'b11, 2'b00, 64'h5,        64'h6,       2'b11, 64'h5,       64'h6, A_ADV);
    tbl[17] = mk("bubble_flushd",0, 0, 8'h40, 2'b01, 2'b00, 64'h9,        64'h9,       2'b00, 64'h0,       64'h0, A_BUB);
    tbl[18] = mk("rst_mid",      1, 0, 8'h00, 2'b11, 2'b00, 64'hE,        64'hF,       2'b00, 64'h0,       64'h0, A_NONE);
    tbl[19] = mk("post_rst",     0, 0, 8'h00, 2'b10, 2'b00, 64'h0,        64'hAB,      2'b01, 64'hAB,      64'h0, A_ADV);

    for (int i = 0; i < 20; i++) begin
      drive_push(tbl[i]);
      clock_check();
    end

    // Long advance run: the 4-bit advance counter must stick at all-ones.
    for (int i = 0; i < 20; i++) begin
      t = mk("sat_run", 0, 0, 8'h00, 2'b11, 2'b00, 64'(i + 1), 64'(i + 100),
             2'b11, 64'(i + 1), 64'(i + 100), A_ADV);
      drive_push(t);
      clock_check();
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("cnt_adv_sat", {{(L*W-CW){1'b0}}, cnt_adv}, {{(L*W-CW){1'b0}}, 4'hF});
`else
    chk("cnt_adv_off", {{(L*W-CW){1'b0}}, cnt_adv}, '0);
`endif

    // A hold then a flush after the saturation run: only the flush counter may move on the flush.
    drive_push(mk("sat_hold", 0, 0, 8'hC0, 2'b00, 2'b00, 64'h0, 64'h0, 2'b11, 64'd20, 64'd119, A_HOLD));
    clock_check();
    drive_push(mk("sat_flush", 0, 1, 8'hC0, 2'b11, 2'b00, 64'h1, 64'h1, 2'b00, 64'h0, 64'h0, A_FL));
    clock_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
